lcd_writer: RTL
===============

Name: lcd_writer

Overview:
- Parametrised HD44780-class character-LCD write engine, replacing the fixed serial-fed LCD driver.
- Accepts bytes over a valid/ready stream from UART or Nios logic.
- Generates RS/E/DB with programmable setup, E-pulse, hold and busy-wait times.
- Adds 8-bit or 4-bit bus mode, an optional in-band escape for instructions, a long wait for clear/home, and a power-on delay.

Parameters:
- BUS_4BIT, 0, 1 = 4-bit interface (two nibble transfers per byte on lcd_db[7:4]), 0 = 8-bit.
- ESC_EN, 1, 1 = byte equal to ESC_CODE arms "next byte is instruction".
- ESC_CODE, 8'h00, escape byte value.
- T_SETUP, 2, clk cycles RS/DB stable before E rises (>=1).
- T_EPW, 12, clk cycles E held high (>=1).
- T_HOLD, 2, clk cycles RS/DB held after E falls (>=1).
- T_WAIT_SHORT, 1000, post-transfer busy cycles for normal data/instructions (>=1).
- T_WAIT_LONG, 41000, post-transfer busy cycles for clear/home instructions (>=1).
- T_POR, 375000, busy cycles after reset before the first accept (>=1).
- CNT_W, 20, timer width; must hold the largest T_* value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  byte offered
- in_ready  out  1  block can accept; a transfer happens on in_valid & in_ready at the clk edge
- in_data  in  8  byte to write
- in_cmd  in  1  1 = instruction (RS=0), 0 = data (RS=1)
- in_single  in  1  4-bit mode only: send high nibble only (init sequence); ignored when BUS_4BIT=0
- busy  out  1  ~in_ready
- lcd_rs  out  1  register select
- lcd_rw  out  1  tied 0 (write only)
- lcd_e  out  1  enable strobe, registered
- lcd_db  out  8  data bus; in 4-bit mode [7:4] = nibble, [3:0] = 0

Behaviour:
- Reset (async, rst_n=0):
  - State POR, timer loaded with T_POR; escape-armed flag cleared.
  - lcd_e=0, lcd_rs=0, lcd_db=0, in_ready=0.
  - Reset mid-pulse forces lcd_e low immediately and discards the byte in flight.
- States: POR, IDLE, SETUP, EHIGH, HOLD, WAIT. in_ready=1 only in IDLE.
- POR: count T_POR cycles, then go to IDLE.
- IDLE, accept:
  - Escape case: ESC_EN=1 and in_cmd=0 and in_data==ESC_CODE and flag clear. Set the flag, produce no bus activity, stay in IDLE (in_ready stays 1).
  - Otherwise: latch the byte. Effective RS = ~(in_cmd | flag); clear the flag.
  - Drive lcd_rs/lcd_db from the next cycle (high nibble first in 4-bit mode), then enter SETUP.
  - A byte received while the flag is armed is always an instruction, even if it equals ESC_CODE.
- SETUP: T_SETUP cycles, lcd_e=0, then EHIGH.
- EHIGH: lcd_e=1 for exactly T_EPW cycles, then HOLD.
- HOLD: lcd_e=0, bus unchanged for T_HOLD cycles. Then:
  - If BUS_4BIT=1, in_single=0 (as latched) and the low nibble is pending: drive the low nibble onto lcd_db[7:4] and return to SETUP.
  - Otherwise go to WAIT.
- WAIT:
  - Count T_WAIT_LONG if the transfer was an instruction with latched byte in 8'h01..8'h03; otherwise T_WAIT_SHORT.
  - Then go to IDLE. The bus keeps its last value.
- Latency:
  - 8-bit or single nibble: accept at edge k → in_ready high again at edge k+1+T_SETUP+T_EPW+T_HOLD+T_WAIT.
  - 4-bit full byte adds T_SETUP+T_EPW+T_HOLD.
- Timer: one CNT_W down-counter, loaded with (T-1) on state entry; advance when it reaches 0. No wrap is possible while the CNT_W rule holds.
- in_valid dropping while not ready has no effect. in_data/in_cmd/in_single are sampled only at accept.

Test Plan:
(params TS=2, TE=3, TH=2, TWS=5, TWL=20, TPOR=10)
- Reset release → in_ready=0 for 10 cycles then 1; lcd_e=0, lcd_db=0 throughout.
- 8-bit, in_cmd=0, in_data=8'h41 → lcd_rs=1, db=8'h41; E high exactly 3 cycles starting 2 cycles after the bus changes; in_ready returns 13 cycles after accept.
- 8-bit: escape 8'h00, then 8'h01 → escape consumes one cycle with no E pulse; 8'h01 sent with rs=0, long wait, in_ready back 1+2+3+2+20=28 cycles after the second accept.
- 8-bit: escape, escape → second byte sent as instruction 8'h00 with short wait; flag clear afterwards (a following 8'h00 re-arms).
- BUS_4BIT=1, data 8'hA5 → two E pulses with db[7:4]=4'hA then 4'h5, db[3:0]=0; with in_single=1 only the 4'hA pulse.
- Assert rst_n=0 during EHIGH → lcd_e falls asynchronously; after release: POR delay again, flag clear, byte not retried.

Source files
------------

// File: rtl/lcd_writer.sv
// lcd_writer -- HD44780-class character-LCD write engine.
//
// Takes bytes from a valid/ready stream and plays them onto an LCD bus
// as RS/E/DB write cycles with programmable setup, enable-pulse, hold and
// post-transfer busy-wait times. Supports 8-bit or 4-bit bus mode, an
// in-band escape byte that turns the following byte into an instruction,
// a long wait after clear/home instructions, and a power-on delay.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   in_valid   byte offered
//   in_ready   engine can accept (only in IDLE)
//   in_data    byte to write
//   in_cmd     1 = instruction (RS=0), 0 = data (RS=1)
//   in_single  4-bit mode only: send the high nibble only
//   busy       ~in_ready
//   lcd_rs     register select
//   lcd_rw     read/write, tied low (write only)
//   lcd_e      enable strobe (registered)
//   lcd_db     data bus; in 4-bit mode [7:4] carries the nibble, [3:0] = 0

module lcd_writer #(
    parameter int         BUS_4BIT     = 0,
    parameter int         ESC_EN       = 1,
    parameter logic [7:0] ESC_CODE     = 8'h00,
    parameter int         T_SETUP      = 2,
    parameter int         T_EPW        = 12,
    parameter int         T_HOLD       = 2,
    parameter int         T_WAIT_SHORT = 1000,
    parameter int         T_WAIT_LONG  = 41000,
    parameter int         T_POR        = 375000,
    parameter int         CNT_W        = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_cmd,
    input  logic       in_single,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    typedef enum logic [2:0] {
        S_POR,
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_HOLD,
        S_WAIT
    } state_t;

    localparam bit L_BUS4 = (BUS_4BIT != 0);
    localparam bit L_ESC  = (ESC_EN != 0);

    // Timer reload values: a state lasting T cycles is entered with T-1.
    localparam logic [CNT_W-1:0] L_POR_M1   = CNT_W'(T_POR - 1);
    localparam logic [CNT_W-1:0] L_SETUP_M1 = CNT_W'(T_SETUP - 1);
    // The first SETUP after an accept also covers the cycle in which the
    // latched byte is moved onto the bus, hence one extra count.
    localparam logic [CNT_W-1:0] L_SETUP_1ST = CNT_W'(T_SETUP);
    localparam logic [CNT_W-1:0] L_EPW_M1   = CNT_W'(T_EPW - 1);
    localparam logic [CNT_W-1:0] L_HOLD_M1  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] L_WS_M1    = CNT_W'(T_WAIT_SHORT - 1);
    localparam logic [CNT_W-1:0] L_WL_M1    = CNT_W'(T_WAIT_LONG - 1);

    state_t           r_state,    w_state_next;
    logic [CNT_W-1:0] r_timer,    w_timer_next;
    logic             r_flag,     w_flag_next;     // escape armed
    logic             r_load,     w_load_next;     // latched byte not yet on the bus
    logic [7:0]       r_byte,     w_byte_next;
    logic             r_rs_pend,  w_rs_pend_next;  // effective RS of the latched byte
    logic             r_low_pend, w_low_pend_next; // low nibble still to send
    logic             r_rs,       w_rs_next;
    logic [7:0]       r_db,       w_db_next;
    logic             r_e,        w_e_next;

    logic             w_timer_zero;
    logic             w_is_esc;
    logic             w_long;
    logic [7:0]       w_first_bus;
    logic [7:0]       w_low_bus;

    assign w_timer_zero = (r_timer == '0);
    assign w_is_esc     = L_ESC && !in_cmd && (in_data == ESC_CODE) && !r_flag;
    // Clear display / return home need the long busy time.
    assign w_long       = !r_rs_pend && (r_byte >= 8'h01) && (r_byte <= 8'h03);
    assign w_first_bus  = L_BUS4 ? {r_byte[7:4], 4'h0} : r_byte;
    assign w_low_bus    = {r_byte[3:0], 4'h0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_POR;
            r_timer    <= L_POR_M1;
            r_flag     <= 1'b0;
            r_load     <= 1'b0;
            r_byte     <= 8'h00;
            r_rs_pend  <= 1'b0;
            r_low_pend <= 1'b0;
            r_rs       <= 1'b0;
            r_db       <= 8'h00;
            r_e        <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_timer    <= w_timer_next;
            r_flag     <= w_flag_next;
            r_load     <= w_load_next;
            r_byte     <= w_byte_next;
            r_rs_pend  <= w_rs_pend_next;
            r_low_pend <= w_low_pend_next;
            r_rs       <= w_rs_next;
            r_db       <= w_db_next;
            r_e        <= w_e_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_timer_next    = r_timer;
        w_flag_next     = r_flag;
        w_load_next     = r_load;
        w_byte_next     = r_byte;
        w_rs_pend_next  = r_rs_pend;
        w_low_pend_next = r_low_pend;
        w_rs_next       = r_rs;
        w_db_next       = r_db;
        w_e_next        = r_e;

        case (r_state)
            S_POR: begin
                if (w_timer_zero) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end

            S_IDLE: begin
                if (in_valid) begin
                    if (w_is_esc) begin
                        // Escape only arms the flag; no bus activity.
                        w_flag_next = 1'b1;
                    end else begin
                        w_byte_next     = in_data;
                        w_rs_pend_next  = ~(in_cmd | r_flag);
                        w_flag_next     = 1'b0;
                        w_low_pend_next = L_BUS4 & ~in_single;
                        w_load_next     = 1'b1;
                        w_timer_next    = L_SETUP_1ST;
                        w_state_next    = S_SETUP;
                    end
                end
            end

            S_SETUP: begin
                if (r_load) begin
                    w_load_next = 1'b0;
                    w_rs_next   = r_rs_pend;
                    w_db_next   = w_first_bus;
                end
                if (w_timer_zero) begin
                    w_state_next = S_EHIGH;
                    w_timer_next = L_EPW_M1;
                    w_e_next     = 1'b1;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end

            S_EHIGH: begin
                if (w_timer_zero) begin
                    w_state_next = S_HOLD;
                    w_timer_next = L_HOLD_M1;
                    w_e_next     = 1'b0;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end

            S_HOLD: begin
                if (w_timer_zero) begin
                    if (r_low_pend) begin
                        w_low_pend_next = 1'b0;
                        w_db_next       = w_low_bus;
                        w_state_next    = S_SETUP;
                        w_timer_next    = L_SETUP_M1;
                    end else begin
                        w_state_next = S_WAIT;
                        w_timer_next = w_long ? L_WL_M1 : L_WS_M1;
                    end
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end

            S_WAIT: begin
                if (w_timer_zero) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end

            default: begin
                w_state_next = S_POR;
                w_timer_next = L_POR_M1;
                w_e_next     = 1'b0;
            end
        endcase
    end

    assign in_ready = (r_state == S_IDLE);
    assign busy     = ~in_ready;
    assign lcd_rs   = r_rs;
    assign lcd_rw   = 1'b0;
    assign lcd_e    = r_e;
    assign lcd_db   = r_db;

endmodule
